dvi_decoder_channel: RTL and testbench
======================================

# dvi_decoder_channel

Receive-side counterpart of the per-channel TMDS encoder and 10:1 serializer. Takes 10-bit parallel words from a 1:10 deserializer in the pixel-clock domain and finds word alignment by hunting for runs of TMDS control tokens. When alignment is lost it issues bitslip pulses back to the deserializer. Once aligned it decodes each word into 8-bit pixel data or the c0/c1 control pair plus data enable. One instance is used per TMDS data channel (blue/green/red) in the DVI receiver top.

## Interface

- SEARCH_CYCLES, 2048: cycles without lock (SEARCH) or without any token (LOCKED) before slip / lock loss; ≥ LOCK_TOKENS+1.
- LOCK_TOKENS, 8: consecutive control tokens required to declare alignment; ≥ 1.
- SLIP_WAIT, 16: settle cycles after a bitslip pulse before searching resumes; ≥ 1.

- pclk  in  1  pixel clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- raw_din  in  10  deserialized word; raw_din[0] is the first bit received on the wire. This matches the encoder's dout[0], which is serialized first.
- bitslip  out  1  one-cycle pulse requesting the deserializer to shift its word boundary by one bit.
- aligned  out  1  high while in LOCKED.
- dout  out  8  decoded pixel byte.
- c0  out  1  control bit 0 (hsync on the blue channel).
- c1  out  1  control bit 1 (vsync on the blue channel).
- de  out  1  data enable.

## Operation

- Control tokens, as raw_din hex:
  - 0x354 → c1c0=00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
  - Any other word is a data word.
- Data decode:
  - d = raw_din[9] ? ~raw_din[7:0] : raw_din[7:0].
  - q[0] = d[0].
  - For i = 1..7: q[i] = raw_din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states are SEARCH (reset state), SLIP, WAIT, and LOCKED.
  - SEARCH:
    - search_cnt increments every cycle.
    - token_run increments on a token and clears to 0 on a data word.
    - When the token_run reaches LOCK_TOKENS (i.e. on the LOCK_TOKENS-th consecutive token) → LOCKED.
    - Otherwise, when search_cnt = SEARCH_CYCLES-1 → SLIP.
    - If both happen in the same cycle, lock wins.
  - SLIP: bitslip=1 for exactly this one cycle → WAIT.
  - WAIT:
    - Counts SLIP_WAIT cycles, then → SEARCH.
    - search_cnt and token_run are cleared on entering SEARCH.
    - Tokens seen during WAIT are ignored.
  - LOCKED:
    - Watchdog clears on every token and increments otherwise.
    - When the watchdog reaches SEARCH_CYCLES-1 on a non-token cycle → SEARCH, with counters cleared.
    - A token arriving on that same cycle keeps the block LOCKED.
- Output register, updated every cycle from raw_din and the state before the edge:
  - Not LOCKED: dout=0, de=0, c0=c1=0.
  - LOCKED, token: dout=0, de=0, c1c0 from the token.
  - LOCKED, data word: dout=q, de=1, c0/c1 hold their previous values.
- The slip count is unbounded; the deserializer wraps its boundary modulo 10 itself.
- Counter widths are sized by $clog2 of the respective parameter. Counters never wrap, because each state exits at its terminal count.

## Timing

- Reset values:
  - bitslip=0, aligned=0, dout=0, c0=0, c1=0, de=0.
  - state=SEARCH, all counters 0.
  - Reset is asynchronous on assertion. Asserting it mid-operation (any state, including during a bitslip pulse) forces these values immediately.
- Decode latency: the raw_din sampled at edge k appears on dout/c0/c1/de after edge k, i.e. 1 cycle.
- aligned rises on the edge that samples the LOCK_TOKENS-th consecutive token. The first decoded output appears on the following edge.
- Slip period with no tokens: SEARCH_CYCLES + 1 + SLIP_WAIT cycles between bitslip pulses. The first pulse occurs SEARCH_CYCLES cycles after reset release.
- aligned falls on the edge that samples the SEARCH_CYCLES-th consecutive non-token word; de is 0 from the next edge.

## Test plan

Use SEARCH_CYCLES=64, LOCK_TOKENS=8, SLIP_WAIT=4 unless noted.

- Lock and decode:
  - 8×0x354 → aligned=1 after the 8th.
  - Then 0x1FF → dout=0x01, de=1.
  - Then 0x300 → dout=0x01.
  - Then 0x0FF → dout=0xFF.
  - Each output appears 1 cycle after its input.
- Token mapping: after lock, 0x354/0x0AB/0x154/0x2AB → (c1,c0)=00/01/10/11, de=0, dout=0.
- Misaligned stream:
  - Stimulus: continuous 0x354 rotated by 3 bits; the bench model rotates back by 1 per bitslip.
  - Required: bitslip pulses at cycles 64, 133, 202.
  - After the third slip, lock occurs 8 cycles into SEARCH.
- Broken run: 7 tokens, 1 data word, 7 tokens → aligned stays 0; the bitslip pulse still arrives at cycle 64.
- Lock loss: after lock, 64 data words 0x1FF → aligned falls on the 64th sample and de=0 thereafter. Repeating with a token inserted at word 64 keeps the block locked.
- Reset mid-operation: assert reset while LOCKED with de=1 → all outputs 0 immediately. After release, the first bitslip pulse comes 64 cycles later if no tokens are applied.

Source files
------------

// File: rtl/dvi_decoder_channel_if.sv
// Per-channel link between a 1:10 deserializer and its TMDS decoder.
// The master side is the deserializer; the slave side is the decoder.
interface dvi_decoder_channel_if;
   logic [9:0] raw_din;
   logic       bitslip;
   logic       aligned;
   logic [7:0] dout;
   logic       c0;
   logic       c1;
   logic       de;

   modport master (
      output raw_din,
      input  bitslip, aligned, dout, c0, c1, de
   );

   modport slave (
      input  raw_din,
      output bitslip, aligned, dout, c0, c1, de
   );
endinterface

// File: rtl/dvi_decoder_channel.sv
// TMDS receive channel: word alignment by control-token hunting,
// bitslip requests to the deserializer, and 10b->8b decode.
module dvi_decoder_channel #(
   parameter int SEARCH_CYCLES = 2048,
   parameter int LOCK_TOKENS   = 8,
   parameter int SLIP_WAIT     = 16
) (
   input logic                 pclk,
   input logic                 reset,
   dvi_decoder_channel_if.slave chan
);

   localparam int CW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
   localparam int TW = (LOCK_TOKENS > 1) ? $clog2(LOCK_TOKENS) : 1;
   localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   typedef enum logic [1:0] {
      SEARCH,
      SLIP,
      WAIT,
      LOCKED
   } state_t;

   state_t        state;
   logic [CW-1:0] search_cnt;
   logic [TW-1:0] token_run;
   logic [WW-1:0] wait_cnt;
   logic          bitslip_q;
   logic          aligned_q;
   logic [7:0]    dout_q;
   logic          c0_q;
   logic          c1_q;
   logic          de_q;

   logic          tok;
   logic [1:0]    tok_c;
   logic [7:0]    d;
   logic [6:0]    x;
   logic [7:0]    q;

   // Recognise the four control tokens and their c1c0 payload.
   always_comb begin
      tok   = 1'b1;
      tok_c = 2'b00;
      unique case (1'b1)
         (chan.raw_din == 10'h354): tok_c = 2'b00;
         (chan.raw_din == 10'h0AB): tok_c = 2'b01;
         (chan.raw_din == 10'h154): tok_c = 2'b10;
         (chan.raw_din == 10'h2AB): tok_c = 2'b11;
         default:                   tok   = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR chain.
   always_comb begin
      d = chan.raw_din[9] ? ~chan.raw_din[7:0] : chan.raw_din[7:0];
      x = d[7:1] ^ d[6:0];
      q = {chan.raw_din[8] ? x : ~x, d[0]};
   end

   // Alignment FSM; search_cnt doubles as the LOCKED watchdog.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         search_cnt <= '0;
         token_run  <= '0;
         wait_cnt   <= '0;
         bitslip_q  <= 1'b0;
         aligned_q  <= 1'b0;
      end else begin
         bitslip_q <= 1'b0;
         case (state)
            SEARCH: begin
               search_cnt <= search_cnt + 1'b1;
               token_run  <= tok ? token_run + 1'b1 : '0;
               if (tok && token_run == TW'(LOCK_TOKENS - 1)) begin
                  state      <= LOCKED;
                  aligned_q  <= 1'b1;
                  search_cnt <= '0;
                  token_run  <= '0;
               end else if (search_cnt == CW'(SEARCH_CYCLES - 1)) begin
                  state      <= SLIP;
                  bitslip_q  <= 1'b1;
                  search_cnt <= '0;
                  token_run  <= '0;
               end
            end
            SLIP: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
                  state      <= SEARCH;
                  search_cnt <= '0;
                  token_run  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            LOCKED: begin
               if (tok) begin
                  search_cnt <= '0;
               end else if (search_cnt == CW'(SEARCH_CYCLES - 1)) begin
                  state      <= SEARCH;
                  aligned_q  <= 1'b0;
                  search_cnt <= '0;
                  token_run  <= '0;
               end else begin
                  search_cnt <= search_cnt + 1'b1;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

   // Registered decode; silent until aligned, c0/c1 hold across data.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         dout_q <= '0;
         de_q   <= 1'b0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end else if (state == LOCKED) begin
         if (tok) begin
            dout_q       <= '0;
            de_q         <= 1'b0;
            {c1_q, c0_q} <= tok_c;
         end else begin
            dout_q <= q;
            de_q   <= 1'b1;
         end
      end else begin
         dout_q <= '0;
         de_q   <= 1'b0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end
   end

   assign chan.bitslip = bitslip_q;
   assign chan.aligned = aligned_q;
   assign chan.dout    = dout_q;
   assign chan.c0      = c0_q;
   assign chan.c1      = c1_q;
   assign chan.de      = de_q;

endmodule

// File: tb/tb_dvi_decoder_channel.sv
// Randomised bench for dvi_decoder_channel against a timestamp-style
// reference model of alignment and TMDS decode.
module tb_dvi_decoder_channel;

   localparam int SC = 64;
   localparam int LT = 8;
   localparam int SW = 4;

   localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   logic pclk;
   logic reset;

   dvi_decoder_channel_if chan ();

   dvi_decoder_channel #(
      .SEARCH_CYCLES (SC),
      .LOCK_TOKENS   (LT),
      .SLIP_WAIT     (SW)
   ) dut (
      .pclk  (pclk),
      .reset (reset),
      .chan  (chan)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int slip_log[$];

   // reference model state
   bit         m_locked;
   int         m_run;
   int         m_since;
   int         m_hold;
   logic       e_bitslip;
   logic       e_aligned;
   logic [7:0] e_dout;
   logic [1:0] e_c;
   logic       e_de;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h",
                  tag, cyc, got, exp);
      end
   endtask

   function automatic int tok_idx(input logic [9:0] w);
      for (int i = 0; i < 4; i++)
         if (w == TOKS[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] ref_dec(input logic [9:0] w);
      logic [7:0] dd;
      logic [7:0] qq;
      dd = w[9] ? ~w[7:0] : w[7:0];
      qq[0] = dd[0];
      for (int i = 1; i < 8; i++)
         qq[i] = w[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
      return qq;
   endfunction

   function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
      logic [19:0] t;
      t = {w, w} >> r;
      return t[9:0];
   endfunction

   function automatic logic [9:0] rnd_data();
      logic [9:0] w;
      do w = 10'($urandom_range(0, 1023));
      while (tok_idx(w) >= 0);
      return w;
   endfunction

   function automatic logic [9:0] rnd_tok();
      return TOKS[$urandom_range(0, 3)];
   endfunction

   task automatic model_reset();
      m_locked  = 0;
      m_run     = 0;
      m_since   = 0;
      m_hold    = 0;
      e_bitslip = 0;
      e_aligned = 0;
      e_dout    = 0;
      e_c       = 0;
      e_de      = 0;
   endtask

   // One edge of the reference model: outputs from the pre-edge state.
   task automatic model_step(input logic [9:0] w);
      int t;
      t = tok_idx(w);
      e_bitslip = 0;
      if (m_locked) begin
         if (t >= 0) begin
            e_dout = 0;
            e_de   = 0;
            e_c    = 2'(t);
         end else begin
            e_dout = ref_dec(w);
            e_de   = 1;
         end
      end else begin
         e_dout = 0;
         e_de   = 0;
         e_c    = 0;
      end
      if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) begin
            m_since = 0;
            m_run   = 0;
         end
      end else if (m_locked) begin
         if (t >= 0) m_since = 0;
         else m_since++;
         if (m_since == SC) begin
            m_locked = 0;
            m_since  = 0;
            m_run    = 0;
         end
      end else begin
         m_since++;
         m_run = (t >= 0) ? m_run + 1 : 0;
         if (m_run == LT) begin
            m_locked = 1;
            m_since  = 0;
            m_run    = 0;
         end else if (m_since == SC) begin
            m_hold    = 1 + SW;
            e_bitslip = 1;
            m_since   = 0;
            m_run     = 0;
         end
      end
      e_aligned = m_locked;
   endtask

   task automatic step(input logic [9:0] w);
      chan.raw_din = w;
      @(posedge pclk);
      model_step(w);
      cyc++;
      @(negedge pclk);
      chk("bitslip", chan.bitslip, e_bitslip);
      chk("aligned", chan.aligned, e_aligned);
      chk("dout", chan.dout, e_dout);
      chk("c1c0", {chan.c1, chan.c0}, e_c);
      chk("de", chan.de, e_de);
      if (chan.bitslip) slip_log.push_back(cyc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bitslip"}, chan.bitslip, 0);
      chk({tag, "_aligned"}, chan.aligned, 0);
      chk({tag, "_dout"}, chan.dout, 0);
      chk({tag, "_c1c0"}, {chan.c1, chan.c0}, 0);
      chk({tag, "_de"}, chan.de, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge pclk);
      chk_zero("rst");
      reset = 1'b0;
      model_reset();
      cyc = 0;
      slip_log.delete();
   endtask

   function automatic int first_slip(input int idx);
      return (slip_log.size() > idx) ? slip_log[idx] : -1;
   endfunction

   initial begin
      int r;
      int lock_cyc;
      reset = 1'b1;
      chan.raw_din = '0;
      model_reset();
      @(negedge pclk);
      do_reset();

      // lock and decode
      for (int i = 0; i < LT; i++) begin
         step(10'h354);
         chk("lock_edge", chan.aligned, (i == LT - 1) ? 1 : 0);
      end
      step(10'h1FF);
      chk("dec_1ff", chan.dout, 8'h01);
      chk("dec_de", chan.de, 1);
      step(10'h300);
      chk("dec_300", chan.dout, 8'h01);
      step(10'h0FF);
      chk("dec_0ff", chan.dout, 8'hFF);

      // token mapping
      for (int k = 0; k < 4; k++) begin
         step(TOKS[k]);
         chk("map_c", {chan.c1, chan.c0}, k);
         chk("map_de", chan.de, 0);
         chk("map_dout", chan.dout, 0);
      end

      // random traffic while locked
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 3) == 0) ? rnd_tok() : rnd_data());

      // lock loss on the SC-th data word
      step(rnd_tok());
      for (int i = 0; i < SC - 1; i++) step(10'h1FF);
      chk("loss_pre", chan.aligned, 1);
      step(10'h1FF);
      chk("loss_fall", chan.aligned, 0);
      step(10'h1FF);
      chk("loss_de", chan.de, 0);

      // a token at word SC keeps lock
      for (int i = 0; i < LT; i++) step(rnd_tok());
      for (int i = 0; i < SC - 1; i++) step(10'h1FF);
      step(rnd_tok());
      chk("keep_lock", chan.aligned, 1);

      // broken run never locks; slip still at SC
      do_reset();
      for (int i = 0; i < LT - 1; i++) step(rnd_tok());
      step(rnd_data());
      for (int i = 0; i < LT - 1; i++) step(rnd_tok());
      while (cyc < SC + 2) step(rnd_data());
      chk("brk_slip", first_slip(0), SC);
      chk("brk_aligned", chan.aligned, 0);

      // misaligned stream: 0x354 rotated by 3, undone per bitslip
      do_reset();
      r = 3;
      for (int k = 0; k < 400 && !chan.aligned; k++) begin
         step(rotr(10'h354, r));
         if (chan.bitslip) r = (r + 9) % 10;
      end
      lock_cyc = chan.aligned ? cyc : -1;
      chk("mis_nslip", slip_log.size(), 3);
      chk("mis_slip0", first_slip(0), SC);
      chk("mis_slip1", first_slip(1), 2 * SC + 1 + SW);
      chk("mis_slip2", first_slip(2), 3 * SC + 2 + 2 * SW);
      chk("mis_lock", lock_cyc, 3 * SC + 3 + 3 * SW + LT);

      // mixed bursts of tokens and data, including slips and relocks
      for (int s = 0; s < 40; s++) begin
         int heavy;
         heavy = $urandom_range(0, 1);
         for (int i = 0; i < 32; i++) begin
            if (heavy != 0)
               step(($urandom_range(0, 9) != 0) ? rnd_tok() : rnd_data());
            else
               step(($urandom_range(0, 19) == 0) ? rnd_tok()
                                                 : 10'($urandom_range(0, 1023)));
         end
      end

      // reset mid-operation while LOCKED with de=1
      for (int i = 0; i < LT; i++) step(rnd_tok());
      step(10'h1FF);
      chk("mid_de", chan.de, 1);
      #2 reset = 1'b1;
      #1 chk_zero("mid");
      @(negedge pclk);
      reset = 1'b0;
      model_reset();
      cyc = 0;
      slip_log.delete();
      for (int i = 0; i < SC + 6; i++) step(rnd_data());
      chk("mid_slip", first_slip(0), SC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
